// File: rtl/comar_mux_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | comar_mux_sched -- two-requester round-robin issue scheduler for a masked mux2    |
// |   gadget, with response tracking. COMAR_SCHED_LFSR_EN selects internal LFSR masks. |
// | Revision: 1.0                                                                     |
// +-----------------------------------------------------------------------------------+
module comar_mux_sched #(
  parameter int          LATENCY   = 2,
  parameter logic [30:0] LFSR_SEED = 31'h2A5F_1C3B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [1:0] req0_a,
  input  logic [1:0] req0_b,
  input  logic [1:0] req0_s,
  input  logic [1:0] req1_a,
  input  logic [1:0] req1_b,
  input  logic [1:0] req1_s,
  output logic [1:0] mux_a,
  output logic [1:0] mux_b,
  output logic [1:0] mux_s,
  output logic [5:0] mux_r,
  input  logic [1:0] mux_c,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [1:0] rsp_c
`ifndef COMAR_SCHED_LFSR_EN
  ,
  input  logic [5:0] rnd_in,
  input  logic       rnd_valid,
  output logic       rnd_ack
`endif
);

  logic             prio_q, prio_d;
  logic [1:0]       mux_a_q, mux_a_d, mux_b_q, mux_b_d, mux_s_q, mux_s_d;
  logic [5:0]       mux_r_q, mux_r_d;
  logic [LATENCY:0] pipe_v_q, pipe_v_d, pipe_id_q, pipe_id_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [1:0]       rsp_c_q, rsp_c_d;
  logic             issue_ok, gnt0, gnt1, xfer;

`ifdef COMAR_SCHED_LFSR_EN
  localparam logic [30:0] SEED_EFF = (LFSR_SEED == 31'h0) ? 31'h1 : LFSR_SEED;
  logic [30:0] lfsr_q, lfsr_d, lfsr_adv;

  // Six Fibonacci steps of x^31+x^28+1; the six newest bits land in [5:0].
  always_comb begin
    lfsr_adv = lfsr_q;
    for (int i = 0; i < 6; i++) begin
      lfsr_adv = {lfsr_adv[29:0], lfsr_adv[30] ^ lfsr_adv[27]};
    end
    lfsr_d = xfer ? lfsr_adv : lfsr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end

  assign issue_ok = 1'b1;
`else
  assign issue_ok = rnd_valid;
  assign rnd_ack  = xfer;
`endif

  // prio_q=1 gives requester 1 precedence when both are valid.
  assign gnt0 = !rst && issue_ok && req0_valid && (!req1_valid || !prio_q);
  assign gnt1 = !rst && issue_ok && req1_valid && (!req0_valid ||  prio_q);
  assign xfer = gnt0 | gnt1;

  always_comb begin
    prio_d      = prio_q;
    mux_a_d     = mux_a_q;
    mux_b_d     = mux_b_q;
    mux_s_d     = mux_s_q;
    mux_r_d     = mux_r_q;
    if (xfer) begin
      prio_d  = gnt0;
      mux_a_d = gnt1 ? req1_a : req0_a;
      mux_b_d = gnt1 ? req1_b : req0_b;
      mux_s_d = gnt1 ? req1_s : req0_s;
`ifdef COMAR_SCHED_LFSR_EN
      mux_r_d = lfsr_adv[5:0];
`else
      mux_r_d = rnd_in;
`endif
    end
    pipe_v_d    = {pipe_v_q[LATENCY-1:0], xfer};
    pipe_id_d   = {pipe_id_q[LATENCY-1:0], gnt1};
    rsp_valid_d = pipe_v_q[LATENCY];
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    if (pipe_v_q[LATENCY]) begin
      rsp_id_d = pipe_id_q[LATENCY];
      rsp_c_d  = mux_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      mux_a_q     <= '0;
      mux_b_q     <= '0;
      mux_s_q     <= '0;
      mux_r_q     <= '0;
      pipe_v_q    <= '0;
      pipe_id_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_c_q     <= '0;
    end else begin
      prio_q      <= prio_d;
      mux_a_q     <= mux_a_d;
      mux_b_q     <= mux_b_d;
      mux_s_q     <= mux_s_d;
      mux_r_q     <= mux_r_d;
      pipe_v_q    <= pipe_v_d;
      pipe_id_q   <= pipe_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mux_a      = mux_a_q;
  assign mux_b      = mux_b_q;
  assign mux_s      = mux_s_q;
  assign mux_r      = mux_r_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_c      = rsp_c_q;

endmodule
`default_nettype wire

// File: tb/tb_comar_mux_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | tb_comar_mux_sched -- directed and randomized bench with a behavioural gadget.    |
// | Revision: 1.0                                                                     |
// +-----------------------------------------------------------------------------------+
module tb_comar_mux_sched;
  localparam int          LAT  = 2;
  localparam logic [30:0] SEED = 31'h2A5F_1C3B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_a = '0, req0_b = '0, req0_s = '0;
  logic [1:0] req1_a = '0, req1_b = '0, req1_s = '0;
  logic [1:0] mux_a, mux_b, mux_s, mux_c;
  logic [5:0] mux_r;
  logic       rsp_valid, rsp_id;
  logic [1:0] rsp_c;
  logic [5:0] rnd_in = '0;
  logic       rnd_valid = 1'b0;
  logic       rnd_ack;

  always #5 clk = ~clk;

  comar_mux_sched #(.LATENCY(LAT), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .mux_a(mux_a), .mux_b(mux_b), .mux_s(mux_s), .mux_r(mux_r), .mux_c(mux_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c)
`ifndef COMAR_SCHED_LFSR_EN
    , .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack)
`endif
  );

`ifdef COMAR_SCHED_LFSR_EN
  assign rnd_ack = 1'b0;
`endif

  // Behavioural gadget: LAT register stages, output freshly re-masked.
  logic [1:0] gad [LAT];
  always @(posedge clk) begin
    logic m;
    m = 1'($urandom_range(0, 1));
    gad[0] <= {m ^ ((^mux_s) ? (^mux_a) : (^mux_b)), m};
    for (int i = 1; i < LAT; i++) gad[i] <= gad[i-1];
  end
  assign mux_c = gad[LAT-1];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state.
  bit         prio_m = 0;
  logic [1:0] em_a = '0, em_b = '0, em_s = '0;
  logic [5:0] em_r = '0;
  logic [LAT:0] ev = '0;
  logic [1:0] eq [$];
  bit         ec_last = 0;
  bit [30:0]  lf_m = SEED;
  int         last_gnt = -1;
  int         rsp_obs = 0;

  function automatic bit [30:0] adv6(input bit [30:0] s);
    bit [30:0] t;
    t = s;
    for (int i = 0; i < 6; i++) t = {t[29:0], t[30] ^ t[27]};
    return t;
  endfunction

  task automatic new_ops(input bit id);
    if (id) begin
      req1_a = 2'($urandom_range(0, 3)); req1_b = 2'($urandom_range(0, 3)); req1_s = 2'($urandom_range(0, 3));
    end else begin
      req0_a = 2'($urandom_range(0, 3)); req0_b = 2'($urandom_range(0, 3)); req0_s = 2'($urandom_range(0, 3));
    end
  endtask

  // One clock cycle: drive after negedge, predict, check after posedge.
  task automatic step(input bit r, input bit v0, input bit v1, input bit rv);
    bit ok, g0, g1, xf, exp_rv;
    logic [1:0] e, a, b, s;
    rst = r; req0_valid = v0; req1_valid = v1; rnd_valid = rv;
    rnd_in = 6'($urandom_range(0, 63));
    #1;
`ifdef COMAR_SCHED_LFSR_EN
    ok = 1'b1;
`else
    ok = rv;
`endif
    g0 = !r && ok && v0 && (!v1 || !prio_m);
    g1 = !r && ok && v1 && (!v0 ||  prio_m);
    xf = g0 | g1;
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
`ifndef COMAR_SCHED_LFSR_EN
    chk("rnd_ack", rnd_ack, xf);
`endif
    exp_rv = r ? 1'b0 : ev[LAT];
    last_gnt = xf ? int'(g1) : -1;
    if (xf) begin
      a = g1 ? req1_a : req0_a; b = g1 ? req1_b : req0_b; s = g1 ? req1_s : req0_s;
      em_a = a; em_b = b; em_s = s;
`ifdef COMAR_SCHED_LFSR_EN
      lf_m = adv6(lf_m);
      em_r = lf_m[5:0];
`else
      em_r = rnd_in;
`endif
      prio_m = g0;
      eq.push_back({g1, (^s) ? (^a) : (^b)});
    end
    ev = {ev[LAT-1:0], xf};
    if (r) begin
      ev = '0; eq.delete(); prio_m = 0; ec_last = 0; lf_m = SEED;
      em_a = '0; em_b = '0; em_s = '0; em_r = '0;
    end
    @(posedge clk); #1;
    chk("mux_a", mux_a, em_a);
    chk("mux_b", mux_b, em_b);
    chk("mux_s", mux_s, em_s);
    chk("mux_r", mux_r, em_r);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (rsp_valid) rsp_obs++;
    if (exp_rv && eq.size() > 0) begin
      e = eq.pop_front();
      chk("rsp_id", rsp_id, e[1]);
      chk("rsp_c", ^rsp_c, e[0]);
      ec_last = e[0];
    end else begin
      chk("rsp_c_hold", ^rsp_c, ec_last);
    end
    @(negedge clk);
    if (g0) new_ops(1'b0);
    if (g1) new_ops(1'b1);
  endtask

  initial begin
    bit p0, p1, v0, v1;
    logic [5:0] gs;
    @(negedge clk);
    repeat (3) step(1, 0, 0, 1);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_c", rsp_c, 2'b00);

    // Single transfer from req0: c = s ? a : b = 1.
    req0_a = 2'b10; req0_b = 2'b00; req0_s = 2'b10;
    step(0, 1, 0, 1);
    rsp_obs = 0;
    repeat (2) step(0, 0, 0, 1);
    chk("single_no_early_rsp", rsp_obs, 0);
    step(0, 0, 0, 1);
    chk("single_rsp_count", rsp_obs, 1);
    chk("single_rsp_c", ec_last, 1'b1);
    chk("single_rsp_c_dut", ^rsp_c, 1'b1);

    // Both valid for 6 cycles after reset: strict alternation from req0.
    step(1, 0, 0, 1);
    gs = '0; rsp_obs = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 1);
      gs = {gs[4:0], last_gnt[0]};
    end
    repeat (5) step(0, 0, 0, 1);
    chk("alt_grants", gs, 6'b010101);
    chk("alt_rsp_count", rsp_obs, 6);

    // Reset with two transfers in flight: nothing emerges afterwards.
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    step(1, 0, 0, 1);
    rsp_obs = 0;
    repeat (10) step(0, 0, 0, 1);
    chk("flush_rsp_count", rsp_obs, 0);
    step(0, 1, 1, 1);
    chk("post_reset_grant", last_gnt, 0);
    repeat (4) step(0, 0, 0, 1);

`ifndef COMAR_SCHED_LFSR_EN
    // No randomness available: req1 must stall.
    rsp_obs = 0;
    repeat (4) begin
      step(0, 0, 1, 0);
      chk("stall_no_grant", last_gnt, -1);
    end
    step(0, 0, 1, 1);
    chk("rnd_grant", last_gnt, 1);
    repeat (4) step(0, 0, 0, 1);
    chk("rnd_rsp_count", rsp_obs, 1);
`else
    // Back-to-back transfers walk the LFSR every edge.
    repeat (64) step(0, 1, 0, 1);
    repeat (4) step(0, 0, 0, 1);
`endif

    // Randomized traffic honouring hold-until-transfer.
    p0 = 0; p1 = 0;
    for (int i = 0; i < 1000; i++) begin
      v0 = p0 | ($urandom_range(0, 2) == 0);
      v1 = p1 | ($urandom_range(0, 2) == 0);
      step(0, v0, v1, $urandom_range(0, 3) != 0);
      p0 = v0 && (last_gnt != 0);
      p1 = v1 && (last_gnt != 1);
    end
    repeat (LAT + 3) step(0, 0, 0, 1);
    chk("queue_drained", eq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/comar_mux_sched.md
COMAR_MUX_SCHED -- requirements
Module: comar_mux_sched

Interface
Parameters:
REQ-001 LATENCY, 2, pipeline depth in clock cycles of the attached first-order mux2 COMAR gadget (input to valid c); legal range 1..8.
REQ-002 LFSR_SEED, 31'h2A5F_1C3B, reset value of the internal mask LFSR; a value of 0 SHALL be replaced by 31'h1.
Ports:
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester N holds an operation.
REQ-006 req0_ready / req1_ready  output  1 each  requester N is granted this cycle.
REQ-007 reqN_a, reqN_b, reqN_s  input  2 each  share pairs {share1,share0} of data a, data b and select s (c = s ? a : b).
REQ-008 mux_a, mux_b, mux_s  output  2 each  registered shares driven to the gadget.
REQ-009 mux_r  output  6  registered fresh randomness driven to the gadget r port.
REQ-010 mux_c  input  2  gadget output shares.
REQ-011 rsp_valid  output  1  one-cycle pulse, result available.
REQ-012 rsp_id  output  1  index of the requester that owns rsp_c.
REQ-013 rsp_c  output  2  result shares.

Function
REQ-014 Transfer on requester N SHALL occur at a rising edge where reqN_valid and reqN_ready are both 1; a requester SHALL hold its inputs stable until transfer.
REQ-015 reqN_ready SHALL be combinational from reqN_valid, the round-robin pointer and issue permission (REQ-024); at most one ready SHALL be high per cycle.
REQ-016 Arbitration: one valid -> grant it; both valid -> grant the requester not granted last; the pointer updates only on transfer.
REQ-017 On transfer, mux_a/mux_b/mux_s SHALL load the granted shares and mux_r SHALL load 6 fresh random bits at the same edge.
REQ-018 Without transfer, mux_a, mux_b, mux_s and mux_r SHALL hold their values; randomness SHALL never be reused across two transfers.
REQ-019 At most one transfer per cycle; back-to-back transfers SHALL sustain one issue per cycle.
REQ-020 A LATENCY+1-deep valid/id shift register SHALL track in-flight issues; a transfer at edge k SHALL produce rsp_valid=1 after edge k+LATENCY+1, with rsp_c = mux_c sampled at that edge and rsp_id = granted index.
REQ-021 rsp_valid SHALL be high for exactly one cycle per transfer; there is no response backpressure.
REQ-022 rsp_c SHALL hold its last value while rsp_valid=0.

Reset
REQ-023 While rst=1 at an edge: reqN_ready=0; mux_a/mux_b/mux_s/mux_r=0; rsp_valid=0, rsp_id=0, rsp_c=0; the round-robin pointer selects requester 0 first; the LFSR loads LFSR_SEED; all in-flight entries are discarded, and no response for them SHALL appear after reset.

Configuration
REQ-024 Macro COMAR_SCHED_LFSR_EN defined: randomness SHALL come from an internal 31-bit Fibonacci LFSR (x^31+x^28+1) advanced 6 steps per transfer, with mux_r = the 6 newest bits, and issue SHALL always be permitted.
REQ-025 Macro undefined: the LFSR SHALL be omitted and input ports rnd_in[5:0] and rnd_valid plus output port rnd_ack (1-bit, combinational, equal to the transfer strobe) SHALL be added; issue SHALL be permitted only when rnd_valid=1, and mux_r SHALL load rnd_in.

Verification
REQ-026 Only req0 valid with a={1,0}, b={0,0}, s={1,0} for one transfer at edge k, LATENCY=2 -> rsp_valid pulse after edge k+3, rsp_id=0, rsp_c share1^share0 = 1.
REQ-027 Both requesters valid for 6 cycles -> grants alternate 0,1,0,1,0,1; six rsp pulses on consecutive cycles with matching ids.
REQ-028 rst asserted one cycle after two transfers -> no rsp_valid pulse for 10 cycles; the next grant with both valid goes to req0.
REQ-029 With the LFSR enabled, 64 consecutive transfers -> mux_r changes at every transfer edge, holds between transfers, and matches the reference LFSR model.
REQ-030 With the LFSR disabled, rnd_valid=0 and req1_valid=1 for 4 cycles -> req1_ready=0 and no transfer; rnd_valid=1 -> transfer with mux_r=rnd_in and a 1-cycle rnd_ack pulse.
REQ-031 Random operand shares over 1000 transfers with random valids -> for every response, unmasked rsp_c equals unmasked (s ? a : b) of the issued operation, in issue order.
